// File: rtl/p_ng_fwd_reader.sv
// p_ng_fwd_reader: drains one ping/pang/pong packet buffer into an AXI-Stream master.
// Reads are credit-limited so the small internal FIFO (RD_LAT+1 entries) can never
// overflow, and the stream still sustains one beat per cycle when m_tready stays high.
// Optional feature macro: P_NG_FWD_PKT_CNT_EN adds a 32-bit pkt_count output.
module p_ng_fwd_reader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int SN_FWD_WIDTH = 64,
    parameter int RD_LAT       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [32:0]               byte_length,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     addr,
    input  logic [SN_FWD_WIDTH-1:0]   odata,
    output logic [SN_FWD_WIDTH-1:0]   m_tdata,
    output logic [SN_FWD_WIDTH/8-1:0] m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready
`ifdef P_NG_FWD_PKT_CNT_EN
    ,
    output logic [31:0]               pkt_count
`endif
);

    localparam int BYTES  = SN_FWD_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int DEPTH  = RD_LAT + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OW     = CNT_W + 1;
    localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);
    localparam logic [32:0]   CAP     = 33'd1 << (ADDR_WIDTH + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                   state_reg, state_next;
    logic [32:0]              n_beats_reg;
    logic [BSHIFT-1:0]        rem_reg;
    logic [32:0]              issued_reg;
    logic [32:0]              sent_reg;
    logic [ADDR_WIDTH-1:0]    addr_reg;
    logic                     overflow_reg;
    logic [RD_LAT-1:0]        pipe_reg;
    logic [SN_FWD_WIDTH-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]         count_reg;

    logic [32:0]              len_clip;
    logic [32:0]              n_beats_next;
    logic [OW-1:0]            outstanding;
    logic                     push, pop, last_beat, last_issue;

    // Length is clipped to the buffer capacity; beat count is ceil(L/BYTES) in 33 bits.
    assign len_clip     = (byte_length > CAP) ? CAP : byte_length;
    assign n_beats_next = (len_clip + 33'(BYTES - 1)) >> BSHIFT;

    assign m_tvalid   = (count_reg != '0);
    assign pop        = m_tvalid && m_tready;
    assign push       = pipe_reg[RD_LAT-1];
    assign last_beat  = (sent_reg == n_beats_reg - 33'd1);
    assign last_issue = (issued_reg + 33'd1 == n_beats_reg);

    // Credits: reads in flight plus FIFO entries that survive this cycle's pop.
    always_comb begin
        outstanding = OW'(count_reg) - OW'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            outstanding = outstanding + OW'(pipe_reg[i]);
        end
    end

    assign rd_en    = (state_reg == ST_RUN) && (outstanding < DEPTH_V);
    assign addr     = addr_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign overflow = overflow_reg;
    assign m_tdata  = m_tvalid ? fifo_mem[rd_ptr_reg] : '0;
    assign m_tlast  = m_tvalid && last_beat;

    // Byte qualifiers: full beats except a short final beat keeps only its top r bytes.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_keep
            assign m_tkeep[gi] = m_tvalid &&
                (!last_beat || (rem_reg == '0) || (gi >= BYTES - int'(rem_reg)));
        end
    endgenerate

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (len_clip == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (rd_en && last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && last_beat) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Packet bookkeeping: length capture, read address and issued/sent counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_beats_reg  <= '0;
            rem_reg      <= '0;
            issued_reg   <= '0;
            sent_reg     <= '0;
            addr_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                n_beats_reg  <= n_beats_next;
                rem_reg      <= len_clip[BSHIFT-1:0];
                overflow_reg <= (byte_length > CAP);
                issued_reg   <= '0;
                sent_reg     <= '0;
                addr_reg     <= '0;
            end else begin
                if (rd_en) begin
                    issued_reg <= issued_reg + 33'd1;
                    // Hold the final address rather than stepping past the buffer end.
                    if (!last_issue) addr_reg <= addr_reg + ADDR_WIDTH'(2);
                end
                if (pop) sent_reg <= sent_reg + 33'd1;
            end
        end
    end

    // Read-latency tracker and FIFO pointers; reset discards reads in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            pipe_reg[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents only matter while count_reg says they are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= odata;
    end

`ifdef P_NG_FWD_PKT_CNT_EN
    // Completed-packet counter, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   pkt_count <= '0;
        else if (state_reg == ST_DONE) pkt_count <= pkt_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_p_ng_fwd_reader.sv
// Directed testbench for p_ng_fwd_reader (ADDR_WIDTH=6 -> CAP=256 bytes, RD_LAT=3).
module tb_p_ng_fwd_reader;

    localparam int AW  = 6;
    localparam int W   = 64;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done, overflow, rd_en, m_tlast, m_tvalid, m_tready;
    logic [32:0]   byte_length;
    logic [AW-1:0] addr;
    logic [W-1:0]  odata, m_tdata;
    logic [7:0]    m_tkeep;
`ifdef P_NG_FWD_PKT_CNT_EN
    logic [31:0]   pkt_count;
`endif

    int checks = 0;
    int errors = 0;

    p_ng_fwd_reader #(.ADDR_WIDTH(AW), .SN_FWD_WIDTH(W), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_length(byte_length),
        .busy(busy), .done(done), .overflow(overflow), .rd_en(rd_en), .addr(addr),
        .odata(odata), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef P_NG_FWD_PKT_CNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    // Buffer model: word w of packet "seed" is {seed, A0, w}; three-cycle read latency.
    logic [31:0] seed;
    logic [W-1:0] rp0, rp1;

    function automatic logic [31:0] word_of(input logic [31:0] s, input int w);
        return {s[7:0], 8'hA0, 16'(w)};
    endfunction

    function automatic logic [63:0] exp_beat(input logic [31:0] s, input int k);
        return {word_of(s, 2 * k), word_of(s, 2 * k + 1)};
    endfunction

    always @(posedge clk) begin
        rp0   <= rd_en ? {word_of(seed, int'(addr)), word_of(seed, int'(addr) + 1)} : 64'h0;
        rp1   <= rp0;
        odata <= rp1;
    end

    // Per-packet capture results.
    logic [63:0]   b_data [64];
    logic [7:0]    b_keep [64];
    logic          b_last [64];
    int            b_cyc  [64];
    logic [AW-1:0] r_addr [64];
    int nbeats, nreads, done_cnt, done_cyc, stall_err;
    logic ovf_seen, busy_end;

    // Runs one packet, recording beats, reads, done pulses and stall-stability violations.
    // mode 0: m_tready=1; mode 1: m_tready 1,0,0 repeating. hold_start keeps start high
    // (with byte_length=0) through the whole packet including the DONE cycle.
    task automatic run_pkt(input logic [32:0] len, input int mode, input bit hold_start);
        int cyc;
        bit pv, pr;
        logic [63:0] pd;
        logic [7:0] pk;
        logic pl;
        nbeats = 0; nreads = 0; done_cnt = 0; done_cyc = -1; stall_err = 0;
        pv = 0; pr = 0; pd = '0; pk = '0; pl = 0;
        @(negedge clk);
        start = 1; byte_length = len; m_tready = 1;
        @(negedge clk);
        if (hold_start) byte_length = 0;
        else start = 0;
        cyc = 0;
        forever begin
            if (done_cyc >= 0) start = 0;
            m_tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl))
                stall_err++;
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast;
            if (m_tvalid && m_tready && nbeats < 64) begin
                b_data[nbeats] = m_tdata; b_keep[nbeats] = m_tkeep;
                b_last[nbeats] = m_tlast; b_cyc[nbeats] = cyc;
                nbeats++;
            end
            if (rd_en && nreads < 64) begin
                r_addr[nreads] = addr;
                nreads++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            ovf_seen = overflow;
            busy_end = busy;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc > 600) begin
                checks++; errors++;
                $display("FAIL timeout len=%0d: no done within 600 cycles (beats=%0d)", len, nbeats);
                break;
            end
            cyc++;
            @(negedge clk);
        end
        start = 0;
        $display("pkt len=%0d mode=%0d beats=%0d reads=%0d done_cyc=%0d ovf=%0b",
                 len, mode, nbeats, nreads, done_cyc, ovf_seen);
    endtask

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d want 0", addr); end
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0)
            begin errors++; $display("FAIL rst_valid_last: got %b%b want 00", m_tvalid, m_tlast); end
        checks++; if (m_tdata !== '0 || m_tkeep !== '0)
            begin errors++; $display("FAIL rst_data_keep: got %h/%h want 0/0", m_tdata, m_tkeep); end
        $display("reset state checked");
    endtask

    task automatic test_full_beats;
        seed = 1;
        run_pkt(33'd16, 0, 0);
        checks++; if (nbeats !== 2) begin errors++; $display("FAIL l16_beats: got %0d want 2", nbeats); end
        checks++; if (nreads !== 2 || r_addr[0] !== 6'd0 || r_addr[1] !== 6'd2)
            begin errors++; $display("FAIL l16_addr: got n=%0d %0d,%0d want 2 0,2", nreads, r_addr[0], r_addr[1]); end
        checks++; if (b_data[0] !== 64'h01A00000_01A00001)
            begin errors++; $display("FAIL l16_data0: got %h want 01a0000001a00001", b_data[0]); end
        checks++; if (b_data[1] !== 64'h01A00002_01A00003)
            begin errors++; $display("FAIL l16_data1: got %h want 01a0000201a00003", b_data[1]); end
        checks++; if (b_keep[0] !== 8'hFF || b_keep[1] !== 8'hFF)
            begin errors++; $display("FAIL l16_keep: got %h,%h want ff,ff", b_keep[0], b_keep[1]); end
        checks++; if (b_last[0] !== 1'b0 || b_last[1] !== 1'b1)
            begin errors++; $display("FAIL l16_last: got %b,%b want 0,1", b_last[0], b_last[1]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL l16_done: got %0d want 1", done_cnt); end
        checks++; if (busy_end !== 1'b0 || ovf_seen !== 1'b0)
            begin errors++; $display("FAIL l16_idle: busy=%b ovf=%b want 0,0", busy_end, ovf_seen); end
    endtask

    task automatic test_partial;
        seed = 2;
        run_pkt(33'd13, 0, 0);
        checks++; if (nbeats !== 2) begin errors++; $display("FAIL l13_beats: got %0d want 2", nbeats); end
        checks++; if (b_keep[0] !== 8'hFF || b_keep[1] !== 8'hF8)
            begin errors++; $display("FAIL l13_keep: got %h,%h want ff,f8", b_keep[0], b_keep[1]); end
        checks++; if (b_last[1] !== 1'b1 || b_data[1] !== exp_beat(2, 1))
            begin errors++; $display("FAIL l13_last: got last=%b data=%h want 1 %h", b_last[1], b_data[1], exp_beat(2, 1)); end
    endtask

    task automatic test_backpressure;
        seed = 3;
        run_pkt(33'd64, 1, 0);
        checks++; if (nbeats !== 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", nbeats); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (b_data[k] !== exp_beat(3, k))
                begin errors++; $display("FAIL bp_data%0d: got %h want %h", k, b_data[k], exp_beat(3, k)); end
        end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stall_err); end
        checks++; if (b_last[7] !== 1'b1 || b_last[6] !== 1'b0)
            begin errors++; $display("FAIL bp_last: got %b,%b want 0,1", b_last[6], b_last[7]); end
    endtask

    task automatic test_zero_length;
        seed = 4;
        run_pkt(33'd0, 0, 0);
        checks++; if (nreads !== 0 || nbeats !== 0)
            begin errors++; $display("FAIL l0_traffic: reads=%0d beats=%0d want 0,0", nreads, nbeats); end
        checks++; if (done_cyc !== 0 || done_cnt !== 1)
            begin errors++; $display("FAIL l0_done: cyc=%0d cnt=%0d want 0,1", done_cyc, done_cnt); end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL l0_busy: got %b want 0", busy_end); end
    endtask

    task automatic test_throughput;
        seed = 7;
        run_pkt(33'd256, 0, 0);
        checks++; if (nbeats !== 32) begin errors++; $display("FAIL cap_beats: got %0d want 32", nbeats); end
        checks++; if (b_cyc[31] - b_cyc[0] !== 31)
            begin errors++; $display("FAIL cap_rate: got span %0d want 31", b_cyc[31] - b_cyc[0]); end
        checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL cap_ovf: got %b want 0", ovf_seen); end
    endtask

    task automatic test_overflow;
        seed = 8;
        run_pkt(33'd257, 0, 0);
        checks++; if (ovf_seen !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_seen); end
        checks++; if (nbeats !== 32 || nreads !== 32)
            begin errors++; $display("FAIL ovf_beats: beats=%0d reads=%0d want 32,32", nbeats, nreads); end
        checks++; if (r_addr[31] !== 6'd62 || addr !== 6'd62)
            begin errors++; $display("FAIL ovf_addr: got %0d/%0d want 62", r_addr[31], addr); end
        checks++; if (b_keep[31] !== 8'hFF || b_last[31] !== 1'b1 || b_data[31] !== exp_beat(8, 31))
            begin errors++; $display("FAIL ovf_last: keep=%h last=%b data=%h", b_keep[31], b_last[31], b_data[31]); end
        seed = 9;
        run_pkt(33'd8, 0, 0);
        checks++; if (ovf_seen !== 1'b0 || nbeats !== 1)
            begin errors++; $display("FAIL ovf_clear: ovf=%b beats=%0d want 0,1", ovf_seen, nbeats); end
    endtask

    task automatic test_start_ignored;
        seed = 10;
        run_pkt(33'd16, 0, 1);
        checks++; if (nbeats !== 2 || b_keep[1] !== 8'hFF)
            begin errors++; $display("FAIL hold_beats: beats=%0d keep=%h want 2 ff", nbeats, b_keep[1]); end
        checks++; if (done_cnt !== 1 || busy_end !== 1'b0)
            begin errors++; $display("FAIL hold_done: cnt=%0d busy=%b want 1,0", done_cnt, busy_end); end
    endtask

    task automatic test_reset_mid;
        seed = 5;
        @(negedge clk); start = 1; byte_length = 33'd64; m_tready = 0;
        @(negedge clk); start = 0;
        repeat (6) @(negedge clk);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", m_tvalid); end
        rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || addr !== '0)
            begin errors++; $display("FAIL mid_ctrl: busy=%b rd_en=%b addr=%0d want 0", busy, rd_en, addr); end
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0)
            begin errors++; $display("FAIL mid_stream: v=%b d=%h k=%h l=%b want 0", m_tvalid, m_tdata, m_tkeep, m_tlast); end
        $display("async reset asserted mid-packet");
        repeat (2) @(negedge clk);
        rst_n = 1;
        seed = 6;
        run_pkt(33'd24, 0, 0);
        checks++; if (nbeats !== 3) begin errors++; $display("FAIL mid_beats: got %0d want 3", nbeats); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (b_data[k] !== exp_beat(6, k))
                begin errors++; $display("FAIL mid_data%0d: got %h want %h", k, b_data[k], exp_beat(6, k)); end
        end
    endtask

    initial begin
        rst_n = 0; start = 0; byte_length = '0; m_tready = 0; seed = 0;
        test_reset;
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_full_beats;
        test_partial;
        test_backpressure;
        test_zero_length;
        test_throughput;
        test_overflow;
        test_start_ignored;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
